// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared channel state encoding and KEY index names.
package key_debounce_pkg;
  typedef enum logic [1:0] {
    S_RELEASED,
    S_PRESS_WAIT,
    S_PRESSED,
    S_RELEASE_WAIT
  } key_state_e;
  localparam int KEY_START = 0;
  localparam int KEY_RST   = 1;
  localparam int KEY_STOP  = 2;
  localparam int KEY_SHOW  = 3;
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel, 2-flop synchronizer, debounce FSM and registered strobes.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_press_nxt
);
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d, press_q, press_d, release_q, release_d;
  logic             key_s, last;
  assign sync_d = {sync_q[0], i_key_n};
  assign key_s  = sync_q[1];
  assign last   = cnt_q == CNT_W'(STABLE_CYCLES - 1);
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      S_RELEASED:   if (!key_s) state_d = S_PRESS_WAIT;
      S_PRESS_WAIT:
        if (key_s) state_d = S_RELEASED;
        else if (last) begin
          state_d = S_PRESSED;
          press_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      S_PRESSED:    if (key_s) state_d = S_RELEASE_WAIT;
      S_RELEASE_WAIT:
        if (!key_s) state_d = S_PRESSED;
        else if (last) begin
          state_d   = S_RELEASED;
          release_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      default:      state_d = S_RELEASED;
    endcase
    level_d = (state_d == S_PRESSED) || (state_d == S_RELEASE_WAIT);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= S_RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end
  assign o_level     = level_q;
  assign o_press     = press_q;
  assign o_release   = release_q;
  assign o_press_nxt = press_d;
endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: NUM_KEYS independent debounce channels plus a registered any-press strobe.
module key_debouncer
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_key_n,
  output logic [NUM_KEYS-1:0] o_level,
  output logic [NUM_KEYS-1:0] o_press,
  output logic [NUM_KEYS-1:0] o_release,
  output logic                o_any_press
);
  logic [NUM_KEYS-1:0] press_nxt;
  logic                any_press_q, any_press_d;
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_ch (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_key_n     (i_key_n[i]),
      .o_level     (o_level[i]),
      .o_press     (o_press[i]),
      .o_release   (o_release[i]),
      .o_press_nxt (press_nxt[i])
    );
  end
  // Built from the channels' next-press values so it lines up with o_press.
  assign any_press_d = |press_nxt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) any_press_q <= 1'b0;
    else          any_press_q <= any_press_d;
  end
  assign o_any_press = any_press_q;
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed scenarios plus random key traffic against a run-length reference model.
module tb_key_debouncer;
  import key_debounce_pkg::*;
  localparam int N  = 4;
  localparam int SC = 4;
  logic         clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0] key_n = '1, level, press, rel;
  logic         any;
  logic [N-1:0] h1, h2, m_level, m_press, m_rel;
  logic         m_any;
  int           run [N];
  int           ncmp = 0, nerr = 0;
  always #5 clk = ~clk;
  key_debouncer #(.NUM_KEYS(N), .STABLE_CYCLES(SC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_n(key_n),
    .o_level(level), .o_press(press), .o_release(rel), .o_any_press(any)
  );
  task automatic mreset();
    h1 = '1; h2 = '1; m_level = '0; m_press = '0; m_rel = '0; m_any = 1'b0;
    for (int c = 0; c < N; c++) run[c] = 0;
  endtask
  task automatic chk();
    ncmp += 4;
    assert (level === m_level) else begin nerr++; $error("FAIL level obs=%b exp=%b t=%0t", level, m_level, $time); end
    assert (press === m_press) else begin nerr++; $error("FAIL press obs=%b exp=%b t=%0t", press, m_press, $time); end
    assert (rel === m_rel) else begin nerr++; $error("FAIL release obs=%b exp=%b t=%0t", rel, m_rel, $time); end
    assert (any === m_any) else begin nerr++; $error("FAIL any_press obs=%b exp=%b t=%0t", any, m_any, $time); end
  endtask
  // A key is accepted once the synchronized value has disagreed with the level for SC+1 edges in a row.
  task automatic step();
    logic [N-1:0] ks;
    logic         want;
    @(posedge clk);
    if (!rst_n) mreset();
    else begin
      ks = h2; h2 = h1; h1 = key_n;
      m_press = '0; m_rel = '0;
      for (int c = 0; c < N; c++) begin
        want = ~ks[c];
        if (want != m_level[c]) begin
          run[c]++;
          if (run[c] == SC + 1) begin
            m_level[c] = want;
            if (want) m_press[c] = 1'b1; else m_rel[c] = 1'b1;
            run[c] = 0;
          end
        end else run[c] = 0;
      end
      m_any = |m_press;
    end
    #1 chk();
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic async_reset();
    rst_n = 1'b0;
    mreset();
    #1 chk();
  endtask
  task automatic measure(input int ch, input bit is_rel, input int exp_k, input string tag);
    int k = 0;
    bit seen = 0;
    while (!seen && k < 20) begin
      step();
      k++;
      seen = is_rel ? rel[ch] : press[ch];
    end
    ncmp++;
    assert (seen && k == exp_k) else begin nerr++; $error("FAIL %s latency obs=%0d seen=%0b exp=%0d", tag, k, seen, exp_k); end
  endtask
  initial begin
    #1 async_reset();
    steps(3);
    rst_n = 1'b1;
    steps(3);
    key_n[KEY_START] = 1'b0;
    measure(KEY_START, 0, SC + 3, "clean_press");
    steps(10);
    key_n[KEY_START] = 1'b1;
    measure(KEY_START, 1, SC + 3, "release");
    steps(8);
    key_n[KEY_STOP] = 1'b0; steps(3);
    key_n[KEY_STOP] = 1'b1; step();
    key_n[KEY_STOP] = 1'b0; steps(2);
    key_n[KEY_STOP] = 1'b1; steps(10);
    key_n[KEY_START] = 1'b0; key_n[KEY_SHOW] = 1'b0;
    measure(KEY_SHOW, 0, SC + 3, "simultaneous");
    steps(5);
    key_n = '1; steps(10);
    key_n[KEY_STOP] = 1'b0; steps(5);
    async_reset();
    key_n[KEY_STOP] = 1'b1; steps(2);
    rst_n = 1'b1; steps(12);
    key_n[KEY_SHOW] = 1'b0; steps(3);
    async_reset(); steps(2);
    rst_n = 1'b1;
    measure(KEY_SHOW, 0, SC + 3, "held_through_reset");
    steps(4);
    key_n[KEY_SHOW] = 1'b1; steps(12);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(0, 7) == 0) key_n[c] = ~key_n[c];
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
        steps($urandom_range(1, 2));
        rst_n = 1'b1;
      end
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
